switch_debounce_map: RTL and testbench
======================================

Name: switch_debounce_map

Overview:
- Parametrised successor to the board switch decoder.
- Synchronises and debounces a NUM_SW-wide raw slide-switch bus on the system clock.
- Produces per-switch rise/fall strobes and decodes the debounced bus into the named control fields.
- Generates change strobes so downstream blocks (song sequencer, ADC mux) react to one clean edge per user action.

Parameters:
- NUM_SW, 16, number of raw switch inputs.
- DEBOUNCE_CYCLES, 100000, consecutive cycles a synced level must persist before it is accepted (≥2; 1 ms at 100 MHz).
- CNT_W, $clog2(DEBOUNCE_CYCLES+2), width of the debounce and settle counters.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- switches  in  NUM_SW  raw asynchronous switch levels.
- sw_stable  out  NUM_SW  debounced switch vector.
- sw_rise  out  NUM_SW  one-cycle strobe per bit on debounced 0→1.
- sw_fall  out  NUM_SW  one-cycle strobe per bit on debounced 1→0.
- settled  out  1  high once the power-up settle window has elapsed.
- raw_data_display_select  out  1  sw_stable[0].
- buzzer_mute  out  1  sw_stable[3].
- volume_control_sw  out  1  sw_stable[4].
- song_select  out  3  sw_stable[11:9].
- adc_method_select  out  1  sw_stable[13].
- ADC_select  out  2  sw_stable[15:14].
- song_change  out  1  strobe: song_select changed this cycle.
- adc_change  out  1  strobe: ADC_select or adc_method_select changed this cycle.
- any_change  out  1  OR of all sw_rise|sw_fall.

Behaviour:
- Interface: one clock, clk. reset_n is asynchronous, active-low. All state is cleared on reset_n low, independent of clk.
- Reset values: sync stages, sw_stable, debounce counters, settle counter, settled, and all strobes = 0. Field outputs are therefore 0.
- Synchroniser: two-flop chain per bit; its output is sync[i]. Raw → sync latency is 2 cycles.
- Settle phase (settled=0):
  - Settle counter increments every cycle from 0.
  - sw_stable <= sync every cycle (no debounce).
  - All strobes held 0; debounce counters held 0.
  - When the counter reaches DEBOUNCE_CYCLES+1, settled <= 1 on that edge; the counter then freezes.
  - Purpose: switches already on at power-up never produce strobes.
- Normal phase (settled=1), per bit i independently:
  - If sync[i]==sw_stable[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: sw_stable[i] <= sync[i], cnt[i] <= 0, and on the same edge sw_rise[i] <= sync[i], sw_fall[i] <= ~sync[i].
  - Else: cnt[i] <= cnt[i]+1.
  - Net: a level must differ from sw_stable for DEBOUNCE_CYCLES consecutive synced cycles. Raw-edge → sw_stable latency is DEBOUNCE_CYCLES+2 cycles.
  - A glitch that returns before acceptance resets the count; no strobe.
- Strobes:
  - Registered, exactly one cycle wide, coincident with the sw_stable update.
  - Cleared to 0 on every edge with no update.
  - A toggle back after acceptance needs a fresh full DEBOUNCE_CYCLES window, so the minimum strobe spacing per bit is DEBOUNCE_CYCLES cycles.
- Field decode: combinational from sw_stable only, zero added latency. Unmapped bits (1,2,5–8,12) appear only in sw_stable/sw_rise/sw_fall.
- Aggregate strobes (combinational from the registered strobes):
  - song_change = |(sw_rise[11:9]|sw_fall[11:9]).
  - adc_change = |(sw_rise[15:13]|sw_fall[15:13]).
  - any_change = |(sw_rise|sw_fall).
- Simultaneous events: bits are independent. Several bits accepted on one edge give one-cycle song_change/adc_change/any_change each, not multiple pulses.
- If NUM_SW<16, field outputs sourced from absent bits read 0.
- Reset mid-operation: all counters, sw_stable, and settled clear asynchronously. On release the settle phase restarts.

Test Plan:
- Reset release with switches=16'h0201 held, DEBOUNCE_CYCLES=4 → settled rises at cycle 6 after release. sw_stable=16'h0201, song_select=3'b001, raw_data_display_select=1. No strobe ever asserted.
- After settled, set switches[3]=1 and hold → sw_stable[3]/buzzer_mute rise exactly 6 cycles after the raw edge, with a sw_rise[3] and any_change pulse of exactly 1 cycle, on the same edge.
- After settled, pulse switches[4] high for 3 cycles (DEBOUNCE_CYCLES=4), then low → sw_stable[4] stays 0; sw_rise and any_change never assert.
- Change switches[11:9] 001→110 in one cycle → single 1-cycle song_change pulse. sw_rise[10], sw_rise[11], and sw_fall[9] pulse on the same edge; song_select=6 afterwards.
- Change switches[15:13] to 3'b101 → one adc_change pulse; ADC_select=2'b10, adc_method_select=1. song_change stays 0.
- Assert reset_n low for 1 cycle mid-debounce (cnt=2) → all outputs 0 immediately. The settle phase reruns; post-settle sw_stable equals the held switches with no strobes.

Source files
------------

// File: rtl/switch_debounce_map.sv
// Slide-switch front end: per-bit 2-flop sync + debounce, power-up settle window,
// edge strobes and decode of the debounced bus into named control fields.

module switch_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic settled,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Before settle the synced level is copied straight through so
    // switches already on at power-up never generate strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            cnt    <= '0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!settled) begin
                stable <= sync;
                cnt    <= '0;
            end else if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= sync;
                cnt    <= '0;
                rise   <= sync;
                fall   <= ~sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

module switch_debounce_map #(
    parameter int NUM_SW          = 16,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 2)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_SW-1:0] switches,
    output logic [NUM_SW-1:0] sw_stable,
    output logic [NUM_SW-1:0] sw_rise,
    output logic [NUM_SW-1:0] sw_fall,
    output logic              settled,
    output logic              raw_data_display_select,
    output logic              buzzer_mute,
    output logic              volume_control_sw,
    output logic [2:0]        song_select,
    output logic              adc_method_select,
    output logic [1:0]        ADC_select,
    output logic              song_change,
    output logic              adc_change,
    output logic              any_change
);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0]  settle_cnt;
    logic [NUM_SW-1:0] sw_event;

    // Counter freezes once settled; only reset restarts the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt <= '0;
            settled    <= 1'b0;
        end else if (!settled) begin
            if (settle_cnt == SETTLE_LAST) settled <= 1'b1;
            else                           settle_cnt <= settle_cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_lane
        switch_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (switches[i]),
            .settled(settled),
            .stable (sw_stable[i]),
            .rise   (sw_rise[i]),
            .fall   (sw_fall[i])
        );
    end

    // Bits beyond NUM_SW read as 0 so narrow builds still elaborate cleanly.
    function automatic logic pick(input logic [NUM_SW-1:0] v, input int idx);
        logic r;
        r = 1'b0;
        for (int k = 0; k < NUM_SW; k++)
            if (k == idx) r = v[k];
        return r;
    endfunction

    assign sw_event = sw_rise | sw_fall;

    assign raw_data_display_select = pick(sw_stable, 0);
    assign buzzer_mute             = pick(sw_stable, 3);
    assign volume_control_sw       = pick(sw_stable, 4);
    assign song_select             = {pick(sw_stable, 11), pick(sw_stable, 10), pick(sw_stable, 9)};
    assign adc_method_select       = pick(sw_stable, 13);
    assign ADC_select              = {pick(sw_stable, 15), pick(sw_stable, 14)};

    assign song_change = pick(sw_event, 9) | pick(sw_event, 10) | pick(sw_event, 11);
    assign adc_change  = pick(sw_event, 13) | pick(sw_event, 14) | pick(sw_event, 15);
    assign any_change  = |sw_event;
endmodule

// File: tb/tb_switch_debounce_map.sv
// Scoreboard bench for switch_debounce_map with DEBOUNCE_CYCLES=4: expected
// per-cycle output snapshots are queued with the stimulus and popped each edge.

module tb_switch_debounce_map;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] switches = 16'h0201;
    logic [15:0] sw_stable, sw_rise, sw_fall;
    logic        settled, raw_data_display_select, buzzer_mute, volume_control_sw;
    logic [2:0]  song_select;
    logic        adc_method_select;
    logic [1:0]  ADC_select;
    logic        song_change, adc_change, any_change;

    switch_debounce_map #(.NUM_SW(16), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset_n(reset_n), .switches(switches),
        .sw_stable(sw_stable), .sw_rise(sw_rise), .sw_fall(sw_fall), .settled(settled),
        .raw_data_display_select(raw_data_display_select), .buzzer_mute(buzzer_mute),
        .volume_control_sw(volume_control_sw), .song_select(song_select),
        .adc_method_select(adc_method_select), .ADC_select(ADC_select),
        .song_change(song_change), .adc_change(adc_change), .any_change(any_change)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] stable;
        logic [15:0] rise;
        logic [15:0] fall;
        logic        settled;
        logic        raw_sel;
        logic        mute;
        logic        vol;
        logic [2:0]  song;
        logic        meth;
        logic [1:0]  adc;
        logic        song_ch;
        logic        adc_ch;
        logic        any_ch;
    } snap_t;

    snap_t       sb[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] exp_st;

    function automatic snap_t mk(input logic [15:0] st, input logic [15:0] r,
                                 input logic [15:0] f, input logic s);
        snap_t x;
        x.stable  = st;
        x.rise    = r;
        x.fall    = f;
        x.settled = s;
        x.raw_sel = st[0];
        x.mute    = st[3];
        x.vol     = st[4];
        x.song    = st[11:9];
        x.meth    = st[13];
        x.adc     = st[15:14];
        x.song_ch = |(r[11:9] | f[11:9]);
        x.adc_ch  = |(r[15:13] | f[15:13]);
        x.any_ch  = |(r | f);
        return x;
    endfunction

    function automatic snap_t observe();
        snap_t x;
        x = {sw_stable, sw_rise, sw_fall, settled, raw_data_display_select, buzzer_mute,
             volume_control_sw, song_select, adc_method_select, ADC_select,
             song_change, adc_change, any_change};
        return x;
    endfunction

    // Queue D+4 cycles where the new level is accepted D+2 edges after the raw change.
    function automatic void push_accept(input logic [15:0] old_st, input logic [15:0] new_st);
        for (int k = 1; k <= D + 4; k++) begin
            if (k < D + 2)       sb.push_back(mk(old_st, 16'h0, 16'h0, 1'b1));
            else if (k == D + 2) sb.push_back(mk(new_st, new_st & ~old_st, old_st & ~new_st, 1'b1));
            else                 sb.push_back(mk(new_st, 16'h0, 16'h0, 1'b1));
        end
    endfunction

    task automatic test_reset();
        snap_t o, e;
        switches = 16'h0201;
        #2 reset_n = 1'b0;
        #1;
        o = observe();
        vectors++;
        if (o !== mk(16'h0, 16'h0, 16'h0, 1'b0)) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", o, mk(16'h0, 16'h0, 16'h0, 1'b0));
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_st = 16'h0201;
        for (int k = 1; k <= 8; k++)
            sb.push_back(mk(k >= 3 ? exp_st : 16'h0, 16'h0, 16'h0, k >= D + 2));
        for (int k = 1; sb.size() > 0; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_settle cyc %0d: got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_debounce();
        snap_t o, e;
        logic [15:0] nxt;
        // Held edge on bit 3 is accepted with a single rise strobe.
        switches[3] = 1'b1;
        nxt = exp_st | 16'h0008;
        push_accept(exp_st, nxt);
        exp_st = nxt;
        for (int k = 1; sb.size() > 0; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL debounce_rise cyc %0d: got %h expected %h", k, o, e);
            end
        end
        // Pulse of D-1 cycles on bit 4 must be rejected.
        switches[4] = 1'b1;
        for (int k = 1; k <= 10; k++) sb.push_back(mk(exp_st, 16'h0, 16'h0, 1'b1));
        for (int k = 1; sb.size() > 0; k++) begin
            @(posedge clk); #1;
            if (k == D - 1) switches[4] = 1'b0;
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL glitch_reject cyc %0d: got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_song_adc();
        snap_t o, e;
        logic [15:0] nxt;
        switches[11:9] = 3'b110;
        nxt = {exp_st[15:12], 3'b110, exp_st[8:0]};
        push_accept(exp_st, nxt);
        exp_st = nxt;
        for (int k = 1; sb.size() > 0; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL song_change cyc %0d: got %h expected %h", k, o, e);
            end
        end
        switches[15:13] = 3'b101;
        nxt = {3'b101, exp_st[12:0]};
        push_accept(exp_st, nxt);
        exp_st = nxt;
        for (int k = 1; sb.size() > 0; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL adc_change cyc %0d: got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        snap_t o, e;
        logic [15:0] hi;
        // A D-cycle pulse is accepted, and the return needs a fresh D window.
        hi = exp_st | 16'h0020;
        switches[5] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k < D + 2)            sb.push_back(mk(exp_st, 16'h0, 16'h0, 1'b1));
            else if (k == D + 2)      sb.push_back(mk(hi, 16'h0020, 16'h0, 1'b1));
            else if (k < 2 * D + 2)   sb.push_back(mk(hi, 16'h0, 16'h0, 1'b1));
            else if (k == 2 * D + 2)  sb.push_back(mk(exp_st, 16'h0, 16'h0020, 1'b1));
            else                      sb.push_back(mk(exp_st, 16'h0, 16'h0, 1'b1));
        end
        for (int k = 1; sb.size() > 0; k++) begin
            @(posedge clk); #1;
            if (k == D) switches[5] = 1'b0;
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %h expected %h", k, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        snap_t o, e;
        switches[1] = 1'b1;
        for (int k = 1; k <= 4; k++) sb.push_back(mk(exp_st, 16'h0, 16'h0, 1'b1));
        for (int k = 1; sb.size() > 0; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL mid_pre cyc %0d: got %h expected %h", k, o, e);
            end
        end
        reset_n = 1'b0;
        #1;
        o = observe();
        vectors++;
        if (o !== mk(16'h0, 16'h0, 16'h0, 1'b0)) begin
            errors++;
            $display("FAIL mid_reset_async: got %h expected %h", o, mk(16'h0, 16'h0, 16'h0, 1'b0));
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        exp_st = switches;
        for (int k = 1; k <= 8; k++)
            sb.push_back(mk(k >= 3 ? exp_st : 16'h0, 16'h0, 16'h0, k >= D + 2));
        for (int k = 1; sb.size() > 0; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL mid_resettle cyc %0d: got %h expected %h", k, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_song_adc();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
